// File: rtl/rxuart.sv
// 8N1 UART receiver: start bit validated at mid-bit, 8 data bits LSB-first at bit centres, stop bit checked.
// Latency: o_wr rises HALF + 9*CLKS_PER_BAUD cycles after the first START cycle (t0); strobes are registered.
// Backpressure: none; a strobe missed downstream loses that byte; o_data holds until the next good byte.
//
// Ports:
//   i_clk        system clock, all logic on the rising edge
//   i_reset      synchronous active-high reset
//   i_uart_rx    asynchronous serial line, idle high
//   o_wr         one-cycle strobe, o_data holds a freshly received byte
//   o_data       last good byte, stable between o_wr strobes
//   o_frame_err  one-cycle strobe, stop bit was sampled low
//   o_busy       high whenever the receiver is not in IDLE
module rxuart #(
    parameter int CLKS_PER_BAUD = 868
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_uart_rx,
    output logic       o_wr,
    output logic [7:0] o_data,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int CW = $clog2(CLKS_PER_BAUD);
    localparam int HALF = CLKS_PER_BAUD / 2;
    localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BAUD - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic          rx_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          wr_q, wr_d;
    logic          fe_q, fe_d;

    // Two-flop synchroniser. Reset to the idle level so a reset never
    // looks like a falling edge on the line.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_uart_rx};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        fe_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF_LD;
                    state_d = START;
                end
            end

            // Re-check the line at the middle of the start bit so a short
            // glitch does not launch a frame.
            START: begin
                if (cnt_q == '0) begin
                    if (!rx_s) begin
                        cnt_d   = FULL_LD;
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = FULL_LD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end

            // Leaving at the stop-bit centre gives half a bit of margin to
            // catch a start bit that follows immediately.
            STOP: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        wr_d    = 1'b1;
                        data_d  = shift_q;
                        state_d = IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end

            // A held-low line (break) must return high before a new start
            // bit can be recognised.
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_wr        = wr_q;
    assign o_data      = data_q;
    assign o_frame_err = fe_q;
    assign o_busy      = (state_q != IDLE);

endmodule
